// File: rtl/ctrl_unit.sv
// Multi-cycle control unit: fetches from a synchronous ROM, decodes, and
// issues accumulator / register-file strobes for one instruction every 3 cycles.
module ctrl_unit #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned REG_BIT_CNT = 3,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned INSTR_W     = 4 + REG_BIT_CNT + DATA_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   run,
  output logic [ADDR_WIDTH-1:0]  rom_addr,
  input  logic [INSTR_W-1:0]     rom_data,
  input  logic                   acc_zero,
  output logic                   acc_we,
  output logic [2:0]             alu_sel,
  output logic [REG_BIT_CNT-1:0] rf_addr,
  output logic                   rf_we,
  output logic [DATA_WIDTH-1:0]  imm,
  output logic                   halted,
  output logic                   busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALT
  } state_e;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_LD   = 4'd1,
    OP_ST   = 4'd2,
    OP_LDI  = 4'd3,
    OP_ADD  = 4'd4,
    OP_SUB  = 4'd5,
    OP_AND  = 4'd6,
    OP_OR   = 4'd7,
    OP_JMP  = 4'd8,
    OP_JZ   = 4'd9,
    OP_HALT = 4'd15
  } op_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [INSTR_W-1:0]    ir_q, ir_d;
  logic [3:0]            opcode;

  assign opcode   = ir_q[INSTR_W-1 -: 4];
  assign rf_addr  = ir_q[DATA_WIDTH+REG_BIT_CNT-1 -: REG_BIT_CNT];
  assign imm      = ir_q[DATA_WIDTH-1:0];
  assign rom_addr = pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (opcode == OP_HALT) state_d = S_HALT;
        else if (run)          state_d = S_FETCH;
        else                   state_d = S_IDLE;
      end
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  // Branch targets land in pc at the end of EXEC, so the next FETCH uses them.
  always_comb begin
    pc_d = pc_q;
    ir_d = ir_q;
    if (state_q == S_DECODE) begin
      ir_d = rom_data;
      pc_d = pc_q + ADDR_WIDTH'(1);
    end else if (state_q == S_EXEC) begin
      if (opcode == OP_JMP || (opcode == OP_JZ && acc_zero))
        pc_d = imm[ADDR_WIDTH-1:0];
    end
  end

  always_comb begin
    acc_we  = 1'b0;
    rf_we   = 1'b0;
    alu_sel = '0;
    if (state_q == S_EXEC) begin
      case (opcode)
        OP_LD:   begin alu_sel = 3'd0; acc_we = 1'b1; end
        OP_ST:   rf_we = 1'b1;
        OP_LDI:  begin alu_sel = 3'd1; acc_we = 1'b1; end
        OP_ADD:  begin alu_sel = 3'd2; acc_we = 1'b1; end
        OP_SUB:  begin alu_sel = 3'd3; acc_we = 1'b1; end
        OP_AND:  begin alu_sel = 3'd4; acc_we = 1'b1; end
        OP_OR:   begin alu_sel = 3'd5; acc_we = 1'b1; end
        default: ;
      endcase
    end
  end

  assign halted = (state_q == S_HALT);
  assign busy   = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_EXEC);

endmodule
